cia_irq_ctrl: RTL and testbench

- Interrupt controller for the CIA: the ICR block that collects the CIA event sources, masks them, raises the IRQ line and implements read-to-clear.
- Sources are timer A underflow, timer B underflow, TOD alarm, serial shift complete and FLAG edge.
- It sits beside the CIA timers on the same register bus (register offset $D) and drives the CIA irq output toward the 6510.
- It replaces the ad-hoc timer-only IRQ logic with full 6526-style mask/set/clear behaviour.

---
 rtl/cia_irq_ctrl.sv | 73 +++++++
 tb/tb_cia_irq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cia_irq_ctrl.sv
// CIA interrupt control register: latches event sources, masks them, drives a
// sticky registered IRQ that is cleared by reading the ICR.
module cia_irq_ctrl #(
  parameter int         NUM_SRC  = 5,
  parameter logic [3:0] ICR_ADDR = 4'hd
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_1mhz_ph1_en,
  input  logic               i_cs,
  input  logic [3:0]         i_addr,
  input  logic               i_we,
  input  logic [7:0]         i_data,
  input  logic [NUM_SRC-1:0] i_src,
  output logic [7:0]         o_data,
  output logic [NUM_SRC-1:0] o_mask,
  output logic               o_irq
);

  logic [NUM_SRC-1:0] flags_reg, flags_next;
  logic [NUM_SRC-1:0] mask_reg, mask_next;
  logic               ir_reg, ir_next;
  logic               irq_reg;
  logic               addr_hit, rd, wr;

  assign addr_hit = (i_addr == ICR_ADDR);
  assign rd       = i_cs & ~i_we & addr_hit;
  assign wr       = i_cs &  i_we & addr_hit;

  // Read data ignores cs/we; the CIA top selects between register blocks.
  always_comb begin
    o_data = 8'h00;
    if (addr_hit) begin
      o_data[7]           = ir_reg;
      o_data[NUM_SRC-1:0] = flags_reg;
    end
  end

  always_comb begin
    flags_next = flags_reg;
    mask_next  = mask_reg;
    ir_next    = ir_reg;
    if (clk_1mhz_ph1_en) begin
      // A source arriving with the clearing read survives into the new flags.
      flags_next = (rd ? '0 : flags_reg) | i_src;
      if (wr) begin
        if (i_data[7]) mask_next = mask_reg | i_data[NUM_SRC-1:0];
        else           mask_next = mask_reg & ~i_data[NUM_SRC-1:0];
      end
      // IR uses the pre-edge flags and mask, giving a one-edge pipeline.
      if (rd) ir_next = 1'b0;
      else    ir_next = ir_reg | (|(flags_reg & mask_reg));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_reg <= '0;
      mask_reg  <= '0;
      ir_reg    <= 1'b0;
      irq_reg   <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      mask_reg  <= mask_next;
      ir_reg    <= ir_next;
      irq_reg   <= ir_next;
    end
  end

  assign o_mask = mask_reg;
  assign o_irq  = irq_reg;

endmodule

// File: tb/tb_cia_irq_ctrl.sv
// Self-checking bench for cia_irq_ctrl: directed scenarios plus random traffic
// compared against a per-source behavioural model.
module tb_cia_irq_ctrl;

  localparam int         NS = 5;
  localparam logic [3:0] AD = 4'hd;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          cs;
  logic [3:0]    addr;
  logic          we;
  logic [7:0]    wdata;
  logic [NS-1:0] src;
  logic [7:0]    rdata;
  logic [NS-1:0] mask;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: one pending bit and one enable bit per source.
  bit m_pend[NS];
  bit m_ena[NS];
  bit m_ir;

  cia_irq_ctrl #(.NUM_SRC(NS), .ICR_ADDR(AD)) dut (
    .clk(clk), .rst(rst), .clk_1mhz_ph1_en(en), .i_cs(cs), .i_addr(addr),
    .i_we(we), .i_data(wdata), .i_src(src), .o_data(rdata), .o_mask(mask),
    .o_irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_data(input logic [3:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == AD) begin
      v[7] = m_ir;
      for (int s = 0; s < NS; s++) v[s] = m_pend[s];
    end
    return v;
  endfunction

  function automatic logic [NS-1:0] model_mask();
    logic [NS-1:0] v;
    for (int s = 0; s < NS; s++) v[s] = m_ena[s];
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_pend[s] = 0;
      m_ena[s]  = 0;
    end
    m_ir = 0;
  endtask

  // One clk edge with the current bus inputs; model advances only when enabled.
  task automatic step(input logic e);
    bit is_rd, is_wr, any_live;
    bit np[NS];
    bit ne[NS];
    is_rd = cs && !we && addr == AD;
    is_wr = cs && we && addr == AD;
    any_live = 0;
    for (int s = 0; s < NS; s++) begin
      if (m_pend[s] && m_ena[s]) any_live = 1;
      np[s] = (is_rd ? 1'b0 : m_pend[s]) || src[s];
      ne[s] = m_ena[s];
      if (is_wr && wdata[s]) ne[s] = wdata[7];
    end
    en = e;
    @(posedge clk);
    if (e) begin
      for (int s = 0; s < NS; s++) begin
        m_pend[s] = np[s];
        m_ena[s]  = ne[s];
      end
      m_ir = is_rd ? 1'b0 : (m_ir || any_live);
    end
    #1;
    en = 1'b0;
  endtask

  task automatic idle();
    cs = 0; we = 0; addr = 4'h0; wdata = 8'h00; src = '0;
  endtask

  task automatic do_write(input logic [7:0] d);
    cs = 1; we = 1; addr = AD; wdata = d; src = '0;
    $display("write ICR data=%02h", d);
    step(1);
    idle();
  endtask

  // Returns the combinational read value seen before the clearing edge.
  task automatic do_read(output logic [7:0] v, input logic [NS-1:0] s_in);
    cs = 1; we = 0; addr = AD; wdata = 8'h00; src = s_in;
    #1;
    v = rdata;
    $display("read ICR data=%02h src=%02h", v, s_in);
    step(1);
    idle();
  endtask

  task automatic pulse(input logic [NS-1:0] s_in);
    idle();
    src = s_in;
    step(1);
    idle();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_write(8'h9f);
    pulse(5'h1f);
    step(1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL reset_pre_irq got=%0b exp=1", irq); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_async_irq got=%0b exp=0", irq); end
    @(posedge clk);
    #1 rst = 1'b1;
    checks++;
    if (mask !== 5'h00) begin failures++; $display("FAIL reset_mask got=%02h exp=00", mask); end
    do_read(v, '0);
    checks++;
    if (v !== 8'h00) begin failures++; $display("FAIL reset_read got=%02h exp=00", v); end
  endtask

  task automatic test_basic();
    logic [7:0] v;
    do_write(8'h81);
    pulse(5'b00001);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL basic_irq_N got=%0b exp=0", irq); end
    step(1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL basic_irq_N1 got=%0b exp=1", irq); end
    do_read(v, '0);
    checks++;
    if (v !== 8'h81) begin failures++; $display("FAIL basic_read got=%02h exp=81", v); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL basic_irq_after_read got=%0b exp=0", irq); end
    do_read(v, '0);
    checks++;
    if (v !== 8'h00) begin failures++; $display("FAIL basic_reread got=%02h exp=00", v); end
  endtask

  task automatic test_masked();
    logic [7:0] v;
    do_write(8'h7f);
    pulse(5'b00010);
    step(1);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL masked_irq got=%0b exp=0", irq); end
    do_read(v, '0);
    checks++;
    if (v !== 8'h02) begin failures++; $display("FAIL masked_read got=%02h exp=02", v); end
    pulse(5'b00010);
    do_write(8'h82);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL late_mask_irq_N got=%0b exp=0", irq); end
    step(1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL late_mask_irq_N1 got=%0b exp=1", irq); end
    do_read(v, '0);
    checks++;
    if (v !== 8'h82) begin failures++; $display("FAIL late_mask_read got=%02h exp=82", v); end
  endtask

  task automatic test_read_race();
    logic [7:0] v;
    do_write(8'h7f);
    do_write(8'h81);
    pulse(5'b00100);
    do_read(v, 5'b00001);
    checks++;
    if (v !== 8'h04) begin failures++; $display("FAIL race_old_value got=%02h exp=04", v); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL race_irq_N got=%0b exp=0", irq); end
    step(1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL race_irq_N1 got=%0b exp=1", irq); end
    do_read(v, '0);
    checks++;
    if (v !== 8'h81) begin failures++; $display("FAIL race_next_read got=%02h exp=81", v); end
  endtask

  task automatic test_mask_setclr();
    logic [7:0] v;
    do_read(v, '0);
    do_write(8'h9f);
    checks++;
    if (mask !== 5'h1f) begin failures++; $display("FAIL mask_set got=%02h exp=1f", mask); end
    do_write(8'h05);
    checks++;
    if (mask !== 5'h1a) begin failures++; $display("FAIL mask_clr got=%02h exp=1a", mask); end
    do_write(8'h7f);
    checks++;
    if (mask !== 5'h00) begin failures++; $display("FAIL mask_clr_all got=%02h exp=00", mask); end
    do_write(8'h81);
    pulse(5'b00001);
    step(1);
    do_write(8'h7f);
    step(1);
    step(1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL sticky_irq got=%0b exp=1", irq); end
    do_read(v, '0);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL sticky_clear got=%0b exp=0", irq); end
  endtask

  task automatic test_enable_gating();
    logic [7:0] v;
    do_write(8'h9a);
    pulse(5'b01000);
    step(1);
    for (int i = 0; i < 6; i++) begin
      cs = 1; addr = AD; we = i[0]; wdata = 8'h7f; src = 5'h1f;
      step(0);
    end
    idle();
    checks++;
    if (mask !== 5'h1a) begin failures++; $display("FAIL gate_mask got=%02h exp=1a", mask); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL gate_irq got=%0b exp=1", irq); end
    addr = AD;
    #1;
    checks++;
    if (rdata !== 8'h88) begin failures++; $display("FAIL gate_flags got=%02h exp=88", rdata); end
    addr = 4'h4; cs = 1;
    #1;
    checks++;
    if (rdata !== 8'h00) begin failures++; $display("FAIL other_addr got=%02h exp=00", rdata); end
    idle();
    do_read(v, '0);
  endtask

  task automatic test_random();
    logic [7:0] exp;
    for (int i = 0; i < 250; i++) begin
      cs    = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : AD;
      wdata = 8'($urandom);
      src   = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      #1;
      exp = model_data(addr);
      checks++;
      if (rdata !== exp) begin failures++; $display("FAIL rand_data cyc=%0d got=%02h exp=%02h", i, rdata, exp); end
      if (cs)
        $display("rand cyc=%0d %s addr=%h wdata=%02h src=%02h", i, we ? "wr" : "rd", addr, wdata, src);
      step(1'($urandom_range(0, 3) != 0));
      checks++;
      if (irq !== m_ir) begin failures++; $display("FAIL rand_irq cyc=%0d got=%0b exp=%0b", i, irq, m_ir); end
      checks++;
      if (mask !== model_mask()) begin failures++; $display("FAIL rand_mask cyc=%0d got=%02h exp=%02h", i, mask, model_mask()); end
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    idle();
    model_reset();
    #23 rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_masked();
    test_read_race();
    test_mask_setclr();
    test_enable_gating();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
